div32_seq: RTL and testbench
============================

# div32_seq

Sequential 32-bit integer divider, the inverse of the existing combinational multiplier in the ALU datapath. It produces quotient and remainder for signed or unsigned operands with a fixed-latency restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the multiplier behind the ALU and serves the DIV/DIVU instructions through a START/BUSY/DONE handshake with the control unit.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- CLK  input  1  system clock, rising edge active.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- A  input  32  dividend; sampled with START.
- B  input  32  divisor; sampled with START.
- BUSY  output  1  high from the accepting edge until DONE is raised.
- DONE  output  1  one-cycle pulse; Q, R and DIV_ZERO are valid in this cycle.
- Q  output  32  quotient; holds until the next accepted START.
- R  output  32  remainder; holds until the next accepted START.
- DIV_ZERO  output  1  set when B == 0; holds with Q and R.

## Operation
- States:
  - IDLE → PREP on START.
  - PREP → CALC, or → DONE_ST if B == 0.
  - CALC → FIX after 32 iterations.
  - FIX → DONE_ST.
  - DONE_ST → IDLE unconditionally.
- PREP:
  - Latch |A| and |B| (negate if SIGNED and MSB set).
  - Record neg_q = A[31]^B[31] and neg_r = A[31]; both are 0 when SIGNED=0.
  - Clear the 33-bit partial remainder and the 5-bit iteration counter.
- CALC, each cycle:
  - rem = {rem[31:0], dvd[31]} and dvd <<= 1.
  - If rem ≥ {1'b0,|B|}: rem -= |B| and shift 1 into the quotient; otherwise shift 0.
  - Counter increments; at count 31 the state moves to FIX.
- FIX:
  - Q = neg_q ? -quot : quot.
  - R = neg_r ? -rem[31:0] : rem[31:0].
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0, no flag.
- Divide by zero: Q=0xFFFFFFFF, R=A (unmodified), DIV_ZERO=1.
- START while BUSY is ignored. Operand changes after the accepting edge have no effect.
- Reset, whether idle or mid-operation: state=IDLE, and BUSY, DONE, Q, R and DIV_ZERO are all 0. The operation is discarded.

## Timing
- Edge 0 is the rising edge that samples START=1 in IDLE. BUSY rises after edge 0.
- Normal path:
  - PREP occupies the cycle after edge 0.
  - CALC iterations occur on edges 2–33.
  - FIX occurs on edge 34.
  - Edge 34 also enters DONE_ST: DONE=1 and BUSY=0 after edge 34, and Q and R are updated at the same edge.
- Divide-by-zero path: DONE after edge 2.
- After DONE the block returns to IDLE on the next edge. A START present in the DONE_ST cycle is ignored; the earliest accepted restart is the first IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIV32_SIGNED_EN defined:
  - The SIGNED input is honoured as described above.
- DIV32_SIGNED_EN undefined:
  - SIGNED is ignored and all operands are treated as unsigned.
  - The negation logic is removed, but PREP and FIX still occupy their cycles, so latency is identical (DONE after edge 34).

## Structure
- The shared definitions file holds:
  - State encodings: IDLE, PREP, CALC, FIX, DONE_ST.
  - DIV_ITER = 32.
  - DIV_LATENCY = 34.
  - The divide-by-zero quotient constant 0xFFFFFFFF.
- One combinational sub-module, div32_step: takes rem[32:0], the next dividend bit and the divisor; returns the new remainder and the quotient bit, using a 33-bit subtract with the borrow as the select.
- The top level holds the FSM, the counter, the operand/quotient shift registers and the sign fix-up.

## Test plan
- Unsigned 100 / 7, SIGNED=0 → Q=14, R=2, DIV_ZERO=0. BUSY high after edges 0–33, DONE for exactly one cycle after edge 34.
- Signed −7 / 2 (0xFFFFFFF9 / 2) → Q=0xFFFFFFFD, R=0xFFFFFFFF. The same bits with SIGNED=0 → Q=0x7FFFFFFC, R=1.
- Signed 0x80000000 / 0xFFFFFFFF → Q=0x80000000, R=0. Unsigned 0xFFFFFFFF / 1 → Q=0xFFFFFFFF, R=0.
- 5 / 0 → Q=0xFFFFFFFF, R=5, DIV_ZERO=1, DONE after edge 2.
- Handshake and operand isolation:
  - Start 100 / 7, then pulse START with 9 / 3 at edge 10 → ignored, and the result stays Q=14, R=2.
  - Change A after edge 0 → no effect on the result.
- Reset and rebuild:
  - Drop RST mid-CALC (edge 12) → outputs 0 immediately, state IDLE.
  - A fresh 50 / 5 afterwards → Q=10, R=0 at edge 34 of the new operation.
  - With DIV32_SIGNED_EN undefined, rerun the signed vector → unsigned results, same latency.

Source files
------------

// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg: shared FSM encoding, latency constants and sign helper for div32_seq.
package div32_seq_pkg;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE_ST} div_state_e;
  localparam int DIV_ITER = 32;
  localparam int DIV_LATENCY = 34;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  function automatic logic [31:0] cond_neg(input logic n, input logic [31:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div32_step.sv
// div32_step: one restoring shift-subtract iteration; the subtract borrow picks restore vs keep.
module div32_step (
  input  logic [32:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] dvs_i,
  output logic [32:0] rem_o,
  output logic        qbit_o
);
  logic [33:0] sh;
  logic [34:0] diff;
  assign sh = {rem_i, bit_i};
  assign diff = {1'b0, sh} - {3'b000, dvs_i};
  assign qbit_o = ~diff[34];
  assign rem_o = diff[34] ? sh[32:0] : diff[32:0];
endmodule

// File: rtl/div32_seq.sv
// div32_seq: sequential 32-bit signed/unsigned restoring divider with START/BUSY/DONE handshake.
// Signed operation is honoured only when DIV32_SIGNED_EN is defined; otherwise all operands are unsigned.
module div32_seq
  import div32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o,
  output logic        div_zero_o
);
`ifdef DIV32_SIGNED_EN
  localparam logic SGN_EN = 1'b1;
`else
  localparam logic SGN_EN = 1'b0;
`endif
  div_state_e  state_q;
  logic [31:0] dvd_q, dvs_q, quot_q, q_q, r_q;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q;
  logic        sgn_q, neg_q_q, neg_r_q, dz_q, busy_q, done_q, div_zero_q, qbit_d;
  div32_step u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[31]),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .qbit_o(qbit_d)
  );
  // Divide-by-zero skips CALC but still passes through FIX so DONE lands after edge 2.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      {dvd_q, dvs_q, quot_q, q_q, r_q, rem_q, cnt_q} <= '0;
      {sgn_q, neg_q_q, neg_r_q, dz_q, busy_q, done_q, div_zero_q} <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          dvd_q <= a_i;
          dvs_q <= b_i;
          sgn_q <= signed_i & SGN_EN;
          busy_q <= 1'b1;
          state_q <= PREP;
        end
        PREP: begin
          dz_q <= dvs_q == '0;
          neg_q_q <= sgn_q & (dvd_q[31] ^ dvs_q[31]);
          neg_r_q <= sgn_q & dvd_q[31];
          dvd_q <= cond_neg(sgn_q & dvd_q[31] & (|dvs_q), dvd_q);
          dvs_q <= cond_neg(sgn_q & dvs_q[31], dvs_q);
          rem_q <= '0;
          cnt_q <= '0;
          state_q <= (dvs_q == '0) ? FIX : CALC;
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[30:0], 1'b0};
          quot_q <= {quot_q[30:0], qbit_d};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          q_q <= dz_q ? DIV_ZERO_Q : cond_neg(neg_q_q, quot_q);
          r_q <= dz_q ? dvd_q : cond_neg(neg_r_q, rem_q[31:0]);
          div_zero_q <= dz_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= DONE_ST;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign q_o = q_q;
  assign r_o = r_q;
  assign div_zero_o = div_zero_q;
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: randomized + directed bench for div32_seq against a latency/arithmetic reference model.
module tb_div32_seq;
`ifdef DIV32_SIGNED_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, signed_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] q_o, r_o;
  int          checks = 0, errors = 0;
  div32_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .signed_i(signed_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .q_o(q_o), .r_o(r_o), .div_zero_o(div_zero_o)
  );
  always #5 clk = ~clk;
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic se;
    se = s & SE;
    if (b == 0) return {1'b1, 32'hFFFF_FFFF, a};
    if (se && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'h0};
    if (se) return {1'b0, 32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
    return {1'b0, a / b, a % b};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_q, m_r;
  logic [64:0] m_pend;
  int          m_left;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_q <= '0; m_r <= '0; m_left <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && !m_done && start_i) begin
        m_busy <= 1'b1;
        m_pend <= ref_div(a_i, b_i, signed_i);
        m_left <= (b_i == 0) ? 2 : div32_seq_pkg::DIV_LATENCY;
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          {m_dz, m_q, m_r} <= m_pend;
        end
      end
    end
  always @(negedge clk) begin
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("done", 32'(done_o), 32'(m_done));
    chk("q", q_o, m_q);
    chk("r", r_o, m_r);
    chk("dz", 32'(div_zero_o), 32'(m_dz));
  end
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [31:0] eq, input logic [31:0] er, input logic edz, input int lat, input logic pulse);
    int n;
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; signed_i = s;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom);
    n = 0;
    while (!done_o && n < 60) begin
      if (pulse && n == 9) begin start_i = 1'b1; a_i = 9; b_i = 3; end
      else start_i = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    chk("latency", n, lat);
    chk("op_q", q_o, eq);
    chk("op_r", r_o, er);
    chk("op_dz", 32'(div_zero_o), 32'(edz));
    @(posedge clk); #1;
  endtask
  initial begin
    logic [64:0] e;
    logic [31:0] ra, rb;
    logic        rs;
    int          n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_q", q_o, 0);
    chk("rst_r", r_o, 0);
    @(negedge clk) rst_n = 1'b1;
    op(100, 7, 1'b0, 14, 2, 1'b0, 34, 1'b0);
    op(32'hFFFF_FFF9, 2, 1'b1, SE ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SE ? 32'hFFFF_FFFF : 32'h1, 1'b0, 34, 1'b0);
    op(32'hFFFF_FFF9, 2, 1'b0, 32'h7FFF_FFFC, 1, 1'b0, 34, 1'b0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, SE ? 32'h8000_0000 : 32'h0, SE ? 32'h0 : 32'h8000_0000, 1'b0, 34, 1'b0);
    op(32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 34, 1'b0);
    op(5, 0, 1'b0, 32'hFFFF_FFFF, 5, 1'b1, 2, 1'b0);
    op(100, 7, 1'b0, 14, 2, 1'b0, 34, 1'b1);
    @(negedge clk);
    start_i = 1'b1; a_i = 100; b_i = 7; signed_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_q", q_o, 0);
    chk("mid_rst_r", r_o, 0);
    chk("mid_rst_dz", 32'(div_zero_o), 0);
    @(negedge clk) rst_n = 1'b1;
    op(50, 5, 1'b0, 10, 0, 1'b0, 34, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 8 == 3) ? 32'h0 : (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i % 5 == 1) ra = {1'b1, 31'($urandom_range(0, 1000))};
      rs = 1'($urandom);
      e = ref_div(ra, rb, rs);
      n = (rb == 0) ? 2 : 34;
      op(ra, rb, rs, e[63:32], e[31:0], e[64], n, 1'(i % 4 == 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
